// File: rtl/scanline_fetch_sched_pkg.sv
// rtl/scanline_fetch_sched_pkg.sv - shared video constants and fetch FSM encoding
package scanline_fetch_sched_pkg;

    localparam int V_ACTIVE_DEF = 240;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARB     = 2'd1,
        ST_WAIT    = 2'd2,
        ST_LOCKOUT = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/scanline_fetch_sched_rr_arbiter.sv
// rtl/scanline_fetch_sched_rr_arbiter.sv - round-robin one-hot pick starting after the pointer
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] eligible,
    input  logic [PW-1:0]   pointer,
    output logic [NREQ-1:0] pick
);

    logic          w_found;
    logic [PW-1:0] w_idx;

    always_comb begin
        pick    = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = PW'((int'(pointer) + k) % NREQ);
            if (!w_found && eligible[w_idx]) begin
                pick[w_idx] = 1'b1;
                w_found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/scanline_fetch_sched.sv
// rtl/scanline_fetch_sched.sv - per-scanline ROM fetch scheduler with round-robin requesters
module scanline_fetch_sched
    import scanline_fetch_sched_pkg::*;
#(
    parameter int NREQ     = 3,
    parameter int AW       = 22,
    parameter int DW       = 32,
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               lhbl,
    input  logic [8:0]         vrender,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ-1:0]    done,
    output logic [NREQ-1:0]    gnt,
    output logic               start,
    output logic [8:0]         render_line,
    output logic               bank,
    output logic               rom_cs,
    output logic [AW-1:0]      rom_addr,
    input  logic               rom_ok,
    input  logic [DW-1:0]      rom_data,
    output logic [DW-1:0]      dout,
    output logic [NREQ-1:0]    dvalid,
    output logic               overrun
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    fetch_state_e    r_state, w_state_nxt;
    logic            r_lhbl_d, r_first, r_active, r_bank, r_start, r_overrun, r_rom_cs;
    logic [NREQ-1:0] r_gnt, r_dvalid, r_done_mask;
    logic [8:0]      r_render_line;
    logic [AW-1:0]   r_rom_addr;
    logic [DW-1:0]   r_dout;
    logic [PW-1:0]   r_ptr;

    logic            w_first_nxt, w_active_nxt, w_bank_nxt, w_start_nxt, w_ovr_nxt, w_cs_nxt;
    logic [NREQ-1:0] w_gnt_nxt, w_dvalid_nxt, w_mask_nxt;
    logic [8:0]      w_line_nxt;
    logic [AW-1:0]   w_addr_nxt;
    logic [DW-1:0]   w_dout_nxt;
    logic [PW-1:0]   w_ptr_nxt;

    logic            w_bnd, w_line_on;
    logic [NREQ-1:0] w_mask, w_elig, w_pick;
    logic [PW-1:0]   w_pick_idx;
    logic [AW-1:0]   w_sel_addr;

    function automatic logic [PW-1:0] oh_idx(input logic [NREQ-1:0] v);
        logic [PW-1:0] idx;
        idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) idx = PW'(i);
        end
        return idx;
    endfunction

    assign w_bnd      = lhbl & ~r_lhbl_d;
    assign w_line_on  = (int'(vrender) < V_ACTIVE);
    // a done arriving in the same cycle as a request takes priority
    assign w_mask     = r_done_mask | done;
    assign w_elig     = req & ~w_mask;
    assign w_pick_idx = oh_idx(w_pick);
    assign w_sel_addr = addr[w_pick_idx*AW +: AW];

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
        .eligible (w_elig),
        .pointer  (r_ptr),
        .pick     (w_pick)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_cs_nxt     = r_rom_cs;
        w_addr_nxt   = r_rom_addr;
        w_dout_nxt   = r_dout;
        w_dvalid_nxt = '0;
        w_start_nxt  = 1'b0;
        w_ovr_nxt    = 1'b0;
        w_bank_nxt   = r_bank;
        w_line_nxt   = r_render_line;
        w_mask_nxt   = w_mask;
        w_ptr_nxt    = r_ptr;
        w_first_nxt  = 1'b0;
        w_active_nxt = r_active;
        if (w_bnd) begin
            // a new line aborts any in-flight fetch, including a coincident rom_ok
            w_bank_nxt   = ~r_bank;
            w_line_nxt   = vrender;
            w_mask_nxt   = '0;
            w_ovr_nxt    = r_active && (r_done_mask != {NREQ{1'b1}});
            w_start_nxt  = w_line_on;
            w_active_nxt = w_line_on;
            w_gnt_nxt    = '0;
            w_cs_nxt     = 1'b0;
            w_state_nxt  = w_line_on ? ST_ARB : ST_LOCKOUT;
        end else begin
            case (r_state)
                ST_ARB: begin
                    if (&w_mask) begin
                        w_state_nxt = ST_LOCKOUT;
                    end else if (|w_elig) begin
                        w_gnt_nxt   = w_pick;
                        w_cs_nxt    = 1'b1;
                        w_addr_nxt  = w_sel_addr;
                        w_ptr_nxt   = w_pick_idx;
                        w_first_nxt = 1'b1;
                        w_state_nxt = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!r_first && rom_ok) begin
                        w_dout_nxt   = rom_data;
                        w_dvalid_nxt = r_gnt;
                        w_gnt_nxt    = '0;
                        w_cs_nxt     = 1'b0;
                        w_state_nxt  = ST_ARB;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_lhbl_d      <= 1'b1;
            r_first       <= 1'b0;
            r_active      <= 1'b0;
            r_bank        <= 1'b0;
            r_start       <= 1'b0;
            r_overrun     <= 1'b0;
            r_rom_cs      <= 1'b0;
            r_gnt         <= '0;
            r_dvalid      <= '0;
            r_done_mask   <= '0;
            r_render_line <= '0;
            r_rom_addr    <= '0;
            r_dout        <= '0;
            r_ptr         <= PW'(NREQ - 1);
        end else begin
            r_state       <= w_state_nxt;
            r_lhbl_d      <= lhbl;
            r_first       <= w_first_nxt;
            r_active      <= w_active_nxt;
            r_bank        <= w_bank_nxt;
            r_start       <= w_start_nxt;
            r_overrun     <= w_ovr_nxt;
            r_rom_cs      <= w_cs_nxt;
            r_gnt         <= w_gnt_nxt;
            r_dvalid      <= w_dvalid_nxt;
            r_done_mask   <= w_mask_nxt;
            r_render_line <= w_line_nxt;
            r_rom_addr    <= w_addr_nxt;
            r_dout        <= w_dout_nxt;
            r_ptr         <= w_ptr_nxt;
        end
    end

    assign gnt         = r_gnt;
    assign start       = r_start;
    assign render_line = r_render_line;
    assign bank        = r_bank;
    assign rom_cs      = r_rom_cs;
    assign rom_addr    = r_rom_addr;
    assign dout        = r_dout;
    assign dvalid      = r_dvalid;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_scanline_fetch_sched.sv
// tb/tb_scanline_fetch_sched.sv - directed and randomized checks of scanline_fetch_sched
module tb_scanline_fetch_sched;

    localparam int NREQ = 3;
    localparam int AW   = 22;
    localparam int DW   = 32;

    logic               clk = 1'b0;
    logic               reset, lhbl;
    logic [8:0]         vrender;
    logic [NREQ-1:0]    req, done;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ-1:0]    gnt, dvalid;
    logic               start, bank, rom_cs, rom_ok, overrun;
    logic [8:0]         render_line;
    logic [AW-1:0]      rom_addr;
    logic [DW-1:0]      rom_data, dout;

    logic [AW-1:0] a_tb [NREQ];
    assign addr = {a_tb[2], a_tb[1], a_tb[0]};

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    scanline_fetch_sched #(.NREQ(NREQ), .AW(AW), .DW(DW), .V_ACTIVE(240)) dut (
        .clk         (clk),
        .reset       (reset),
        .lhbl        (lhbl),
        .vrender     (vrender),
        .req         (req),
        .addr        (addr),
        .done        (done),
        .gnt         (gnt),
        .start       (start),
        .render_line (render_line),
        .bank        (bank),
        .rom_cs      (rom_cs),
        .rom_addr    (rom_addr),
        .rom_ok      (rom_ok),
        .rom_data    (rom_data),
        .dout        (dout),
        .dvalid      (dvalid),
        .overrun     (overrun)
    );

    function automatic logic [DW-1:0] model_data(input logic [AW-1:0] a);
        return {a[9:0], a} ^ 32'h5A5A1234;
    endfunction

    function automatic int oh2i(input logic [NREQ-1:0] v);
        if ($countones(v) != 1) return -1;
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    // round-robin rule: first eligible requester after the last one granted
    function automatic int rr_next(input int last, input logic [NREQ-1:0] el);
        for (int k = 1; k <= NREQ; k++) begin
            if (el[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    // ROM answers two cycles after chip select rises
    int rom_cnt = 0;
    always @(posedge clk) rom_cnt <= rom_cs ? rom_cnt + 1 : 0;
    assign rom_ok   = rom_cs && (rom_cnt >= 2);
    assign rom_data = (rom_addr == 22'h12345) ? 32'hDEADBEEF : model_data(rom_addr);

    int            gq[$];
    logic [AW-1:0] aq[$];
    logic [2:0]    dvq[$];
    logic [DW-1:0] dq[$];
    int            last_g = NREQ - 1;
    int            n_start = 0, n_csbad = 0, n_dvbad = 0;
    logic [2:0]    prev_gnt = '0, prev_dv = '0;

    always @(negedge clk) begin
        if (gnt != 3'b000 && prev_gnt == 3'b000) begin
            gq.push_back(oh2i(gnt));
            aq.push_back(rom_addr);
            last_g = oh2i(gnt);
        end
        if (dvalid != 3'b000) begin
            dvq.push_back(dvalid);
            dq.push_back(dout);
        end
        if (dvalid != 3'b000 && prev_dv != 3'b000) n_dvbad++;
        if (rom_cs !== (gnt != 3'b000)) n_csbad++;
        if (start) n_start++;
        prev_gnt = gnt;
        prev_dv  = dvalid;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // returns in the first cycle of the new line
    task automatic boundary(input logic [8:0] vr);
        vrender = vr;
        lhbl    = 1'b0;
        tick();
        lhbl    = 1'b1;
        tick();
    endtask

    initial begin
        int b, bd, s0, nbad, lastg, e, idx;
        logic [2:0] rq;
        int exp_order[4];
        exp_order = '{0, 1, 2, 0};

        reset = 1'b1; lhbl = 1'b1; vrender = '0; req = '0; done = '0;
        a_tb[0] = 22'h00100; a_tb[1] = 22'h12345; a_tb[2] = 22'h3ABCD;
        ticks(3);
        chk("rst_gnt", gnt, 0);
        chk("rst_cs", rom_cs, 0);
        chk("rst_dvalid", dvalid, 0);
        chk("rst_start", start, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_bank", bank, 0);
        chk("rst_line", render_line, 0);
        chk("rst_addr", rom_addr, 0);
        chk("rst_dout", dout, 0);
        reset = 1'b0;
        ticks(2);

        // all three requesting: grants rotate 0,1,2,0
        req = 3'b111;
        s0  = n_start;
        b   = gq.size();
        boundary(9'd10);
        chk("t1_start", start, 1);
        chk("t1_line", render_line, 10);
        chk("t1_bank", bank, 1);
        chk("t1_overrun", overrun, 0);
        tick();
        chk("t1_start_pulse", start, 0);
        for (int k = 0; k < 60 && gq.size() < b + 4; k++) tick();
        chk("t1_ngrants", gq.size() >= b + 4, 1);
        if (gq.size() >= b + 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("t1_order", gq[b+k], exp_order[k]);
                chk("t1_addr", aq[b+k], a_tb[exp_order[k]]);
            end
        end
        chk("t1_start_once", n_start - s0, 1);

        // single requester: address captured at grant, data returned once
        req = 3'b010;
        for (int k = 0; k < 20 && gnt != 0; k++) tick();
        for (int k = 0; k < 20 && gnt == 0; k++) tick();
        chk("t2_gnt", gnt, 3'b010);
        chk("t2_cs", rom_cs, 1);
        chk("t2_addr", rom_addr, 22'h12345);
        a_tb[1] = 22'h3FFFF;
        tick();
        chk("t2_addr_held", rom_addr, 22'h12345);
        for (int k = 0; k < 10 && dvalid == 0; k++) tick();
        chk("t2_dvalid", dvalid, 3'b010);
        chk("t2_dout", dout, 32'hDEADBEEF);
        tick();
        chk("t2_dvalid_pulse", dvalid, 0);
        a_tb[1] = 22'h12345;

        // done[0] removes requester 0 for the rest of the line
        req  = 3'b011;
        done = 3'b001;
        tick();
        done = 3'b000;
        b = gq.size();
        ticks(30);
        nbad = 0;
        for (int k = b; k < gq.size(); k++) if (gq[k] != 1) nbad++;
        chk("t3_only1", nbad, 0);
        chk("t3_some_grants", gq.size() > b, 1);
        done = 3'b110;
        tick();
        done = 3'b000;
        ticks(10);
        b = gq.size();
        ticks(20);
        chk("t3_lockout_nogrant", gq.size() - b, 0);
        chk("t3_lockout_cs", rom_cs, 0);

        // boundary with done_mask 101 aborts in-flight fetch of requester 1
        boundary(9'd20);
        chk("t4_no_overrun", overrun, 0);
        chk("t4_start", start, 1);
        chk("t4_bank", bank, 0);
        req  = 3'b111;
        done = 3'b101;
        tick();
        done = 3'b000;
        for (int k = 0; k < 10 && gnt == 0; k++) tick();
        chk("t4_gnt", gnt, 3'b010);
        tick();
        boundary(9'd30);
        chk("t4_overrun", overrun, 1);
        chk("t4_start2", start, 1);
        chk("t4_bank2", bank, 1);
        chk("t4_cs_drop", rom_cs, 0);
        chk("t4_gnt_drop", gnt, 0);
        chk("t4_no_dvalid", dvalid, 0);
        tick();
        chk("t4_overrun_pulse", overrun, 0);
        chk("t4_no_dvalid2", dvalid, 0);

        // out-of-range line is idle; the next one does not report overrun
        boundary(9'd250);
        chk("t5_overrun", overrun, 1);
        chk("t5_no_start", start, 0);
        chk("t5_line", render_line, 250);
        b = gq.size();
        ticks(20);
        chk("t5_no_grants", gq.size() - b, 0);
        chk("t5_no_cs", rom_cs, 0);
        boundary(9'd0);
        chk("t5_next_no_overrun", overrun, 0);
        chk("t5_next_start", start, 1);

        // reset in the middle of a fetch
        for (int k = 0; k < 20 && gnt == 0; k++) tick();
        chk("t6_in_wait", rom_cs, 1);
        reset = 1'b1;
        tick();
        chk("t6_cs", rom_cs, 0);
        chk("t6_bank", bank, 0);
        chk("t6_gnt", gnt, 0);
        reset = 1'b0;
        tick();
        boundary(9'd5);
        chk("t6_no_overrun", overrun, 0);
        chk("t6_start", start, 1);
        chk("t6_bank2", bank, 1);
        for (int k = 0; k < 10 && gnt == 0; k++) tick();
        chk("t6_first_gnt", gnt, 3'b001);

        // randomized lines against the round-robin rule and ROM contents
        for (int ln = 0; ln < 6; ln++) begin
            req = '0;
            ticks(10);
            lastg = last_g;
            for (int i = 0; i < NREQ; i++) begin
                a_tb[i] = AW'($urandom);
                if (a_tb[i] == 22'h12345) a_tb[i] = 22'h12344;
            end
            rq = 3'($urandom_range(1, 7));
            b  = gq.size();
            bd = dvq.size();
            boundary(9'($urandom_range(0, 239)));
            chk("rnd_overrun", overrun, 1);
            req = rq;
            ticks(40);
            req = '0;
            ticks(10);
            chk("rnd_some_grants", gq.size() > b, 1);
            for (int k = b; k < gq.size(); k++) begin
                e = rr_next(lastg, rq);
                chk("rnd_order", gq[k], e);
                if (e >= 0) chk("rnd_addr", aq[k], a_tb[e]);
                lastg = e;
            end
            chk("rnd_ndvalid", dvq.size() - bd, gq.size() - b);
            for (int k = bd; k < dvq.size(); k++) begin
                idx = oh2i(dvq[k]);
                chk("rnd_dv_onehot", idx >= 0 && rq[idx], 1);
                if (idx >= 0) chk("rnd_dout", dq[k], model_data(a_tb[idx]));
            end
        end

        chk("cs_matches_gnt", n_csbad, 0);
        chk("dvalid_single_cycle", n_dvbad, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/scanline_fetch_sched.md
SCANLINE_FETCH_SCHED -- requirements
Module: scanline_fetch_sched

Interface
REQ-001 Parameters SHALL be: NREQ, default 3, number of fetch requesters; AW, default 22, ROM address width; DW, default 32, ROM data width; V_ACTIVE, default 240, rendered lines per frame.
REQ-002 Ports SHALL be (name direction width meaning): clk in 1 system clock; reset in 1 reset.
REQ-003 lhbl in 1 horizontal blank (active low), from the video timer; vrender in 9 line being rendered, from the video timer.
REQ-004 req in NREQ fetch requests; addr in NREQ*AW request addresses (slice i = requester i); done in NREQ requester finished its line (1-cycle pulse).
REQ-005 gnt out NREQ one-hot grant; start out 1 line-start pulse; render_line out 9 latched line number; bank out 1 line-buffer write bank.
REQ-006 rom_cs out 1 ROM chip select; rom_addr out AW ROM address; rom_ok in 1 ROM data ready; rom_data in DW ROM data.
REQ-007 dout out DW fetched data; dvalid out NREQ one-hot data strobe; overrun out 1 line-deadline-missed pulse.
REQ-008 There SHALL be one clock, clk; reset SHALL be synchronous and active-high, port name reset.

Function
REQ-009 A line boundary SHALL be the cycle after lhbl is sampled 1 following a sample of 0 (registered rising edge of lhbl).
REQ-010 At a line boundary: bank toggles; render_line <= vrender; done mask clears. If vrender < V_ACTIVE, start pulses 1 cycle and the line is active; otherwise the line is idle and all req is ignored.
REQ-011 FSM states SHALL be IDLE, ARB, WAIT, and LOCKOUT (line finished or idle).
- IDLE->ARB on an active boundary.
- IDLE->LOCKOUT on an idle boundary.
REQ-012 ARB: eligible = req & ~done_mask. If nonzero, round-robin pick starting at the index after the last granted. Next cycle: gnt one-hot, rom_cs=1, rom_addr = latched addr slice; state -> WAIT.
REQ-013 ARB when all done_mask bits are set SHALL go to LOCKOUT.
REQ-014 WAIT SHALL ignore rom_ok in the first cycle after rom_cs rises. A later rom_ok=1 SHALL produce, in the next cycle:
- dout=rom_data (registered);
- dvalid=gnt for exactly 1 cycle;
- gnt=0, rom_cs=0;
- state -> ARB.
REQ-015 Grant-to-grant minimum spacing SHALL be 3 cycles (grant, ok, ARB); the requester address SHALL be captured at grant and held constant until release.
REQ-016 done[i] SHALL set done_mask[i] until the next boundary. If done[i] and req[i] coincide, done wins. done from the granted requester SHALL NOT abort its in-flight fetch.
REQ-017 Deadline: if a boundary occurs while the previous line was active and done_mask is not all ones, overrun SHALL pulse 1 cycle with start.
REQ-018 A boundary in WAIT SHALL abort the fetch: rom_cs, gnt drop that cycle, no dvalid, and rom_ok in the same cycle is discarded. The new line then proceeds per REQ-010.
REQ-019 A boundary during a dvalid cycle SHALL keep that dvalid; arbitration restarts for the new line.
REQ-020 The round-robin pointer SHALL persist across lines and wrap from NREQ-1 to 0.

Reset
REQ-021 reset=1 SHALL force, on the next edge:
- state IDLE;
- gnt, dvalid, start, overrun, rom_cs = 0;
- rom_addr, dout = 0;
- bank=0, render_line=0, done_mask=0;
- rr pointer = NREQ-1 (first grant to requester 0);
- edge detector lhbl history = 1.
REQ-022 Reset asserted mid-WAIT SHALL drop rom_cs in the same edge; the first boundary after reset release SHALL not assert overrun.

Structure
REQ-023 The FSM state encoding and the V_ACTIVE default SHALL live in the shared video package.
REQ-024 The round-robin selector SHALL be one sub-module, rr_arbiter (inputs eligible, pointer; output one-hot pick). Everything else SHALL be in a single module.

Verification
REQ-025 Bench (NREQ=3, rom_ok 2 cycles after cs) SHALL cover:
- req=3'b111 constant, vrender=10 boundary -> grants in order 0,1,2,0; start=1 once; render_line=10.
- req[1] with addr=0x12345, rom_data=0xDEADBEEF -> rom_addr=0x12345 while cs; dout=0xDEADBEEF, dvalid=3'b010 for 1 cycle.
- done[0] pulse while req=3'b011 -> only requester 1 granted thereafter; all done -> LOCKOUT, no cs.
- boundary with done_mask=3'b101 -> overrun=1 for 1 cycle; bank toggles; in-flight cs dropped, no dvalid.
- vrender=250 boundary -> no start, no grants despite req=3'b111; next vrender=0 boundary -> no overrun.
- reset asserted during WAIT -> rom_cs=0, bank=0 next edge; first grant after release to requester 0.
